// File: rtl/data_mem.sv
// Word-addressed data memory for the single-cycle MIPS datapath: combinational
// loads, edge-committed stores, immediate and sticky access-fault reporting.
module data_mem #(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memWr,
    input  logic        memRd,
    input  logic [31:0] addr,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic        fault,
    output logic        fault_sticky,
    output logic [15:0] wr_count
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam logic [32:0] SPAN_33  = 33'(DEPTH) * 33'd4;

    logic [31:0]      mem_r [DEPTH];
    logic [15:0]      wr_count_r;
    logic             fault_sticky_r;

    logic [32:0]      offset_s;
    logic [IDX_W-1:0] idx_s;
    logic             misaligned_s;
    logic             out_of_range_s;
    logic             req_s;
    logic             fault_s;
    logic             wr_ok_s;
    logic             rd_ok_s;
    logic [31:0]      rd_data_s;

    // Address decode; the 33-bit difference exposes addresses below the base via its borrow bit.
    always_comb begin
        offset_s       = {1'b0, addr} - {1'b0, BASE_ADDR};
        idx_s          = offset_s[IDX_W+1:2];
        misaligned_s   = (addr[1:0] != 2'b00);
        out_of_range_s = offset_s[32] | ({1'b0, offset_s[31:0]} >= SPAN_33);
        req_s          = memWr | memRd;
        fault_s        = req_s & (misaligned_s | out_of_range_s);
        wr_ok_s        = memWr & ~fault_s;
        rd_ok_s        = memRd & ~fault_s;
    end

    // Load path: reads the pre-write contents so a same-cycle store shows old data.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        if (rd_ok_s) begin
            rd_data_s = mem_r[idx_s];
        end else begin
            rd_data_s = 32'h0000_0000;
        end
    end

    // Storage array with asynchronous clear of every word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (wr_ok_s) begin
            mem_r[idx_s] <= dataIn;
        end
    end

    // Store counter and sticky fault flag, updated on the same edge as the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_r     <= 16'h0000;
            fault_sticky_r <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wr_count_r <= wr_count_r + 16'h0001;
            end
            if (fault_s) begin
                fault_sticky_r <= 1'b1;
            end
        end
    end

    assign dataOut      = rd_data_s;
    assign fault        = fault_s;
    assign fault_sticky = fault_sticky_r;
    assign wr_count     = wr_count_r;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed cases plus randomized accesses
// compared against an array-based reference model.
module tb_data_mem;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        memWr;
    logic        memRd;
    logic [31:0] addr;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic        fault;
    logic        fault_sticky;
    logic [15:0] wr_count;

    logic [31:0] exp_mem [DEPTH];
    logic [15:0] exp_count;
    logic        exp_sticky;
    int          n_checks;
    int          n_pass;

    data_mem #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .memWr(memWr), .memRd(memRd),
        .addr(addr), .dataIn(dataIn), .dataOut(dataOut), .fault(fault),
        .fault_sticky(fault_sticky), .wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic model_fault(input logic wr, input logic rd, input logic [31:0] a);
        longint unsigned la;
        logic oor;
        la  = longint'(a);
        oor = (la < longint'(BASE)) || (la >= longint'(BASE) + 4 * longint'(DEPTH));
        return (wr | rd) & ((a % 4 != 0) | oor);
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) exp_mem[i] = 32'h0000_0000;
        exp_count  = 16'h0000;
        exp_sticky = 1'b0;
    endtask

    // One full access: drive, check combinational outputs mid-cycle, then registered ones after the edge.
    task automatic access(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
        logic        f;
        logic [31:0] ed;
        memWr = wr; memRd = rd; addr = a; dataIn = d;
        f  = model_fault(wr, rd, a);
        ed = (rd && !f) ? exp_mem[model_idx(a)] : 32'h0000_0000;
        @(negedge clk);
        check("fault", {31'h0, fault}, {31'h0, f});
        check("dataOut", dataOut, ed);
        @(posedge clk);
        if (wr && !f) begin
            exp_mem[model_idx(a)] = d;
            exp_count++;
        end
        if (f) exp_sticky = 1'b1;
        #1;
        check("wr_count", {16'h0, wr_count}, {16'h0, exp_count});
        check("fault_sticky", {31'h0, fault_sticky}, {31'h0, exp_sticky});
        memWr = 1'b0; memRd = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst_n = 1'b0; memWr = 1'b0; memRd = 1'b1; addr = 32'h0000_0010; dataIn = 32'h0;
        model_clear();
        #2;
        check("reset_dataOut", dataOut, 32'h0);
        check("reset_wr_count", {16'h0, wr_count}, 32'h0);
        check("reset_sticky", {31'h0, fault_sticky}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; memRd = 1'b0;

        // Store then load.
        access(1'b1, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF);
        access(1'b0, 1'b1, 32'h0000_0008, 32'h0);
        check("store_load_count", {16'h0, wr_count}, 32'h1);

        // Same-cycle read/write: old data before the edge, new after.
        access(1'b1, 1'b0, 32'h0000_000C, 32'h1234_5678);
        access(1'b1, 1'b1, 32'h0000_000C, 32'hCAFE_0000);
        access(1'b0, 1'b1, 32'h0000_000C, 32'h0);

        // Range boundaries before any fault, then faulting cases.
        access(1'b1, 1'b0, 32'h0000_00FC, 32'hA5A5_0001);
        access(1'b0, 1'b1, 32'h0000_00FC, 32'h0);
        access(1'b1, 1'b0, 32'h0000_0100, 32'hBAD0_0100);
        access(1'b0, 1'b1, 32'h0000_00FC, 32'h0);
        access(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);

        // Misaligned store leaves memory and count alone; sticky stays set.
        access(1'b1, 1'b0, 32'h0000_0006, 32'h7777_7777);
        access(1'b0, 1'b1, 32'h0000_0004, 32'h0);
        access(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0);

        // Randomized mix of legal, misaligned and out-of-range accesses.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 5))
                0:       a = $urandom;
                1:       a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd4 + 32'($urandom_range(1, 3));
                2:       a = BASE + 32'd4 * 32'(DEPTH) + 32'($urandom_range(0, 15)) * 32'd4;
                default: a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
            endcase
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
        end

        // Held stores up to the counter limit, then one more to wrap it.
        memWr = 1'b1; memRd = 1'b0;
        while (exp_count != 16'hFFFF) begin
            addr   = BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
            dataIn = $urandom;
            @(posedge clk);
            exp_mem[model_idx(addr)] = dataIn;
            exp_count++;
            #1;
        end
        memWr = 1'b0;
        check("count_ffff", {16'h0, wr_count}, 32'h0000_FFFF);
        access(1'b1, 1'b0, 32'h0000_0010, 32'h0BAD_F00D);
        check("count_wrap", {16'h0, wr_count}, 32'h0);
        access(1'b0, 1'b1, 32'h0000_0010, 32'h0);

        // Asynchronous reset mid-cycle during a store discards it.
        memWr = 1'b1; memRd = 1'b1; addr = 32'h0000_0010; dataIn = 32'h5555_AAAA;
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("midreset_dataOut", dataOut, 32'h0);
        check("midreset_wr_count", {16'h0, wr_count}, 32'h0);
        check("midreset_sticky", {31'h0, fault_sticky}, 32'h0);
        @(posedge clk); #1;
        memWr = 1'b0;
        rst_n = 1'b1;
        access(1'b0, 1'b1, 32'h0000_0010, 32'h0);
        access(1'b0, 1'b1, 32'h0000_0008, 32'h0);
        access(1'b1, 1'b0, 32'h0000_0020, 32'h1111_2222);
        access(1'b0, 1'b1, 32'h0000_0020, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
